// File: rtl/mips_debug_display_pkg.sv
// Shared types, segment font and blanking helper for the mips debug display.
// Leading-zero blanking is enabled by defining DEBUG_DISPLAY_BLANK_EN.
package mips_debug_pkg;

    typedef enum logic [1:0] {
        DM_TRACE,
        DM_WDATA,
        DM_STORE,
        DM_COUNT
    } disp_mode_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g..a} patterns for 0..F
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bit i set when nibbles 7..i are all zero; digit 0 is never blanked
    function automatic logic [7:0] lz_mask(input logic [31:0] v);
        logic [7:0] m;
        logic       z;
        m = '0;
        z = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            z    = z & (v[4*i +: 4] == 4'h0);
            m[i] = z;
        end
        return m;
    endfunction

endpackage

// File: rtl/mips_debug_display_hex7seg.sv
// Combinational nibble to active-low 7-segment pattern.
// Uses the shared font table from mips_debug_pkg.
module hex7seg
    import mips_debug_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[nib];

endmodule

// File: rtl/mips_debug_display.sv
// Multiplexed 8-digit debug display and store monitor for the mips core.
// Define DEBUG_DISPLAY_BLANK_EN to blank leading zeros in modes 1 and 3.
module mips_debug_display
    import mips_debug_pkg::*;
#(
    parameter int N        = 32,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int LED_W    = 20
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pclow,
    input  logic [4:0]        state,
    input  logic [N-1:0]      dataadr,
    input  logic [N-1:0]      writedata,
    input  logic              memwrite,
    input  logic [1:0]        mode,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              store_led
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    logic [DW-1:0]    div;
    logic [IW-1:0]    idx;
    logic             term;
    logic             wrap;
    logic [15:0]      cap_adr;
    logic [15:0]      cap_dat;
    logic [N-1:0]     store_cnt;
    logic [LED_W-1:0] stretch;
    logic [LED_W-1:0] stretch_nxt;
    logic [31:0]      frame;
    logic [31:0]      frame_nxt;
    logic [7:0]       blank;
    logic [7:0]       blank_nxt;
    disp_mode_t       frm_mode;
    disp_mode_t       mode_e;
    logic [3:0]       nib;
    logic [6:0]       font;

    wire unused_ok = ^{dataadr, writedata, store_cnt};

    assign mode_e = disp_mode_t'(mode);
    assign term   = (div == DW'(SCAN_DIV - 1));
    assign wrap   = term && (idx == IW'(DIGITS - 1));

    // Snapshot uses register values, so a coincident store shows next frame
    always_comb begin
        frame_nxt = '0;
        unique case (mode_e)
            DM_TRACE: frame_nxt = {pclow, 3'b000, state, dataadr[15:0]};
            DM_WDATA: frame_nxt = writedata[31:0];
            DM_STORE: frame_nxt = {cap_adr, cap_dat};
            DM_COUNT: frame_nxt = store_cnt[31:0];
            default:  frame_nxt = '0;
        endcase
    end

`ifdef DEBUG_DISPLAY_BLANK_EN
    assign blank_nxt = (mode_e == DM_WDATA || mode_e == DM_COUNT)
                     ? lz_mask(frame_nxt) : 8'h00;
`else
    assign blank_nxt = 8'h00;
`endif

    always_comb begin
        stretch_nxt = stretch;
        if (memwrite)
            stretch_nxt = '1;
        else if (stretch != '0)
            stretch_nxt = stretch - 1'b1;
    end

    assign nib = frame[{idx, 2'b00} +: 4];

    hex7seg u_hex (
        .nib (nib),
        .seg (font)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            idx <= '0;
        end else if (term) begin
            div <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_adr   <= '0;
            cap_dat   <= '0;
            store_cnt <= '0;
            stretch   <= '0;
        end else begin
            stretch <= stretch_nxt;
            if (memwrite) begin
                cap_adr <= dataadr[15:0];
                cap_dat <= writedata[15:0];
                if (store_cnt != '1)
                    store_cnt <= store_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame    <= '0;
            blank    <= '0;
            frm_mode <= DM_TRACE;
        end else if (wrap) begin
            frame    <= frame_nxt;
            blank    <= blank_nxt;
            frm_mode <= mode_e;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an        <= '1;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
            store_led <= 1'b0;
        end else begin
            an        <= ~({{(DIGITS-1){1'b0}}, 1'b1} << idx);
            seg       <= blank[idx] ? SEG_BLANK : font;
            dp        <= !((idx == IW'(4)) &&
                           (frm_mode == DM_TRACE || frm_mode == DM_STORE));
            store_led <= (stretch_nxt != '0);
        end
    end

endmodule

// File: tb/tb_mips_debug_display.sv
// Directed bench for mips_debug_display with a 4-cycle digit dwell.
// Honours DEBUG_DISPLAY_BLANK_EN for leading-zero expectations.
module tb_mips_debug_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  pclow = '0;
    logic [4:0]  state = '0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        memwrite = 1'b0;
    logic [1:0]  mode = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        store_led;

    int vecs = 0;
    int errs = 0;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

`ifdef DEBUG_DISPLAY_BLANK_EN
    localparam logic [7:0] LZ5 = 8'hFE;
`else
    localparam logic [7:0] LZ5 = 8'h00;
`endif

    mips_debug_display #(
        .N        (32),
        .DIGITS   (8),
        .SCAN_DIV (4),
        .LED_W    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pclow     (pclow),
        .state     (state),
        .dataadr   (dataadr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .mode      (mode),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .store_led (store_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lands on the first sample of digit 0 of the next frame
    task automatic sync_frame();
        int n;
        n = 0;
        while (an !== 8'h7F && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (an !== 8'hFE && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sync", {31'd0, n < 100}, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] exp,
                               input bit dpon, input logic [7:0] bl,
                               input int sw_d, input logic [1:0] sw_m);
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 4; c++) begin
                ea = ~(8'h01 << d);
                chk({tag, ".an"}, {24'd0, an}, {24'd0, ea});
                if (c == 0) begin
                    es = bl[d] ? 7'h7F : FONT[exp[4*d +: 4]];
                    ed = !(dpon && d == 4);
                    chk({tag, ".seg"}, {25'd0, seg}, {25'd0, es});
                    chk({tag, ".dp"}, {31'd0, dp}, {31'd0, ed});
                    if (d == sw_d)
                        mode = sw_m;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int n;

        // 1: reset values, release latency, async reset mid-scan
        repeat (3) @(negedge clk);
        chk("rst.an", {24'd0, an}, 32'hFF);
        chk("rst.seg", {25'd0, seg}, 32'h7F);
        chk("rst.dp", {31'd0, dp}, 32'd1);
        chk("rst.led", {31'd0, store_led}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel.an", {24'd0, an}, 32'hFE);
        chk("rel.seg", {25'd0, seg}, 32'h40);
        memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre.led", {31'd0, store_led}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async.an", {24'd0, an}, 32'hFF);
        chk("async.seg", {25'd0, seg}, 32'h7F);
        chk("async.dp", {31'd0, dp}, 32'd1);
        chk("async.led", {31'd0, store_led}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel2.an", {24'd0, an}, 32'hFE);

        // 2: trace mode field mapping
        mode = 2'd0;
        pclow = 8'h3C;
        state = 5'd9;
        dataadr = 32'h0000_0054;
        sync_frame();
        sync_frame();
        check_frame("t2", 32'h3C09_0054, 1'b1, 8'h00, -1, 2'd0);

        // 3: store capture and LED stretch
        dataadr = 32'h0000_0080;
        writedata = 32'hDEAD_BEEF;
        memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        dataadr = 32'h0000_0054;
        n = 0;
        while (store_led === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("t3.led_len", n, 32'd15);
        mode = 2'd2;
        sync_frame();
        sync_frame();
        check_frame("t3", 32'h0080_BEEF, 1'b1, 8'h00, -1, 2'd0);

        // 4: store count saturates
        mode = 2'd3;
        @(negedge clk);
        force dut.store_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.store_cnt;
        memwrite = 1'b1;
        repeat (3) @(negedge clk);
        memwrite = 1'b0;
        sync_frame();
        sync_frame();
        check_frame("t4", 32'hFFFF_FFFF, 1'b0, 8'h00, -1, 2'd0);

        // 5: mode change mid-frame takes effect next frame
        mode = 2'd1;
        writedata = 32'h1234_5678;
        sync_frame();
        sync_frame();
        check_frame("t5a", 32'h1234_5678, 1'b0, 8'h00, 3, 2'd0);
        check_frame("t5b", 32'h3C09_0054, 1'b1, 8'h00, -1, 2'd0);

        // 6: count of five, blanked or not by build
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            memwrite = 1'b1;
            @(negedge clk);
            memwrite = 1'b0;
            @(negedge clk);
        end
        mode = 2'd3;
        sync_frame();
        sync_frame();
        check_frame("t6", 32'h0000_0005, 1'b0, LZ5, -1, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
